tuner_pwr_detect_multi: RTL and testbench

Multi-channel sweep peak detector for microring tuning. It accepts per-step ADC power samples for `NUM_CH` rings together with the tuning code of the current sweep step. It averages `2**AVG_LOG2` samples per step and tracks each channel's maximum averaged power and the tuning code where that maximum occurred. At sweep end it reports the results through a valid/ready handshake. It sits between the ADC bank and the tuner control FSM, and generalises the single-channel power detect PHY.

---
 rtl/wdm_pkg.sv | 16 +
 rtl/tuner_pwr_detect_ch.sv | 64 ++++++
 rtl/tuner_pwr_detect_multi.sv | 147 ++++++++++++++
 tb/tb_tuner_pwr_detect_multi.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wdm_pkg.sv
// rtl/wdm_pkg.sv - shared state type and width helper for the tuner power detector
package wdm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    REPORT  = 2'd3
  } tuner_pwr_detect_state_e;

  // A group of 2**avg_log2 full-scale samples needs avg_log2 extra bits of headroom.
  function automatic int sum_width(input int adc_width, input int avg_log2);
    return adc_width + avg_log2;
  endfunction

endpackage

// File: rtl/tuner_pwr_detect_ch.sv
// rtl/tuner_pwr_detect_ch.sv - per-channel group sum, average and peak/min tracker (min under TUNER_PWR_DETECT_MIN_EN)
module tuner_pwr_detect_ch
  import wdm_pkg::*;
#(
  parameter int ADC_WIDTH = 8,
  parameter int AVG_LOG2  = 2,
  parameter int IDX_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 acc,
  input  logic                 cmp,
  input  logic                 discard,
  input  logic                 clear,
  input  logic                 first,
  input  logic [ADC_WIDTH-1:0] pwr,
  input  logic [IDX_WIDTH-1:0] grp_idx,
  output logic [ADC_WIDTH-1:0] peak_pwr,
  output logic [IDX_WIDTH-1:0] peak_idx
`ifdef TUNER_PWR_DETECT_MIN_EN
  ,
  output logic [ADC_WIDTH-1:0] min_pwr,
  output logic [IDX_WIDTH-1:0] min_idx
`endif
);

  localparam int SUM_W = sum_width(ADC_WIDTH, AVG_LOG2);

  logic [SUM_W-1:0]     sum;
  logic [ADC_WIDTH-1:0] avg;

  // Dropping the low AVG_LOG2 bits is the truncating divide by the group size.
  assign avg = sum[SUM_W-1:AVG_LOG2];

  // Accumulate beats, then on compare update the extremes; strict compares keep the earlier index on ties.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sum      <= '0;
      peak_pwr <= '0;
      peak_idx <= '0;
`ifdef TUNER_PWR_DETECT_MIN_EN
      min_pwr  <= '0;
      min_idx  <= '0;
`endif
    end else begin
      if (cmp || discard) begin
        sum <= '0;
      end else if (acc) begin
        sum <= sum + SUM_W'(pwr);
      end
      if (cmp && (first || avg > peak_pwr)) begin
        peak_pwr <= avg;
        peak_idx <= grp_idx;
      end
`ifdef TUNER_PWR_DETECT_MIN_EN
      if (cmp && (first || avg < min_pwr)) begin
        min_pwr <= avg;
        min_idx <= grp_idx;
      end
`endif
    end
  end

endmodule

// File: rtl/tuner_pwr_detect_multi.sv
// rtl/tuner_pwr_detect_multi.sv - multi-channel sweep peak detector top; TUNER_PWR_DETECT_MIN_EN adds minimum tracking
module tuner_pwr_detect_multi
  import wdm_pkg::*;
#(
  parameter int ADC_WIDTH = 8,
  parameter int NUM_CH    = 4,
  parameter int AVG_LOG2  = 2,
  parameter int IDX_WIDTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_active,
  input  logic                          i_refresh,
  input  logic                          i_sample_val,
  output logic                          o_sample_rdy,
  input  logic [NUM_CH*ADC_WIDTH-1:0]   i_sample_pwr,
  input  logic [IDX_WIDTH-1:0]          i_sample_idx,
  input  logic                          i_sweep_last,
  output logic                          o_detect_val,
  input  logic                          i_detect_rdy,
  output logic [NUM_CH*ADC_WIDTH-1:0]   o_detect_pwr,
  output logic [NUM_CH*IDX_WIDTH-1:0]   o_detect_idx,
`ifdef TUNER_PWR_DETECT_MIN_EN
  output logic [NUM_CH*ADC_WIDTH-1:0]   o_detect_min_pwr,
  output logic [NUM_CH*IDX_WIDTH-1:0]   o_detect_min_idx,
`endif
  output logic                          o_busy
);

  localparam int               CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  tuner_pwr_detect_state_e state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_WIDTH-1:0] grp_idx;
  logic                 first_grp;
  logic                 grp_full;
  logic                 grp_last;

  logic in_sweep, start, abort, refresh, handshake, beat, close;
  logic ch_cmp, ch_disc, ch_clear;

  // Abort outranks refresh, and both outrank a same-cycle beat.
  assign in_sweep  = (state == ACCUM) || (state == COMPARE);
  assign start     = (state == IDLE) && i_active;
  assign abort     = in_sweep && !i_active;
  assign refresh   = in_sweep && i_active && i_refresh;
  assign handshake = (state == REPORT) && i_detect_rdy;
  assign beat      = (state == ACCUM) && i_sample_val && !abort && !refresh;
  assign close     = beat && (i_sweep_last || cnt == CNT_LAST);
  assign ch_cmp    = (state == COMPARE) && grp_full && !abort && !refresh;
  assign ch_disc   = (state == COMPARE) && !grp_full && !abort && !refresh;
  assign ch_clear  = start || abort || refresh || handshake;

  assign o_sample_rdy = (state == ACCUM);
  assign o_detect_val = (state == REPORT);
  assign o_busy       = (state != IDLE);

  // Sweep sequencing: group beat counting, group index latch and the first-group flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      grp_idx   <= '0;
      first_grp <= 1'b0;
      grp_full  <= 1'b0;
      grp_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_active) begin
            state     <= ACCUM;
            cnt       <= '0;
            first_grp <= 1'b1;
          end
        end
        ACCUM: begin
          if (abort) begin
            state     <= IDLE;
            cnt       <= '0;
            first_grp <= 1'b0;
          end else if (refresh) begin
            // A refresh restarts the sweep, so the next full group seeds the records again.
            state     <= ACCUM;
            cnt       <= '0;
            first_grp <= 1'b1;
          end else if (beat) begin
            if (cnt == '0) grp_idx <= i_sample_idx;
            if (close) begin
              state    <= COMPARE;
              cnt      <= '0;
              grp_full <= (cnt == CNT_LAST);
              grp_last <= i_sweep_last;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        COMPARE: begin
          if (abort) begin
            state     <= IDLE;
            first_grp <= 1'b0;
          end else if (refresh) begin
            state     <= ACCUM;
            first_grp <= 1'b1;
          end else begin
            if (grp_full) first_grp <= 1'b0;
            state <= grp_last ? REPORT : ACCUM;
          end
        end
        REPORT: begin
          if (i_detect_rdy) begin
            first_grp <= 1'b1;
            state     <= i_active ? ACCUM : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    tuner_pwr_detect_ch #(
      .ADC_WIDTH (ADC_WIDTH),
      .AVG_LOG2  (AVG_LOG2),
      .IDX_WIDTH (IDX_WIDTH)
    ) u_ch (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .acc      (beat),
      .cmp      (ch_cmp),
      .discard  (ch_disc),
      .clear    (ch_clear),
      .first    (first_grp),
      .pwr      (i_sample_pwr[k*ADC_WIDTH +: ADC_WIDTH]),
      .grp_idx  (grp_idx),
      .peak_pwr (o_detect_pwr[k*ADC_WIDTH +: ADC_WIDTH]),
      .peak_idx (o_detect_idx[k*IDX_WIDTH +: IDX_WIDTH])
`ifdef TUNER_PWR_DETECT_MIN_EN
      ,
      .min_pwr  (o_detect_min_pwr[k*ADC_WIDTH +: ADC_WIDTH]),
      .min_idx  (o_detect_min_idx[k*IDX_WIDTH +: IDX_WIDTH])
`endif
    );
  end

endmodule

// File: tb/tb_tuner_pwr_detect_multi.sv
// tb/tb_tuner_pwr_detect_multi.sv - self-checking bench for tuner_pwr_detect_multi (TUNER_PWR_DETECT_MIN_EN adds min checks)
module tb_tuner_pwr_detect_multi;

  localparam int AW  = 8;
  localparam int NCH = 2;
  localparam int AL  = 2;
  localparam int IW  = 8;
  localparam int GRP = 4;

  logic              i_clk = 1'b0;
  logic              i_rst_n, i_active, i_refresh, i_sample_val, i_sweep_last, i_detect_rdy;
  logic              o_sample_rdy, o_detect_val, o_busy;
  logic [NCH*AW-1:0] i_sample_pwr, o_detect_pwr;
  logic [IW-1:0]     i_sample_idx;
  logic [NCH*IW-1:0] o_detect_idx;
`ifdef TUNER_PWR_DETECT_MIN_EN
  logic [NCH*AW-1:0] o_detect_min_pwr;
  logic [NCH*IW-1:0] o_detect_min_idx;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  tuner_pwr_detect_multi #(
    .ADC_WIDTH (AW),
    .NUM_CH    (NCH),
    .AVG_LOG2  (AL),
    .IDX_WIDTH (IW)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_active     (i_active),
    .i_refresh    (i_refresh),
    .i_sample_val (i_sample_val),
    .o_sample_rdy (o_sample_rdy),
    .i_sample_pwr (i_sample_pwr),
    .i_sample_idx (i_sample_idx),
    .i_sweep_last (i_sweep_last),
    .o_detect_val (o_detect_val),
    .i_detect_rdy (i_detect_rdy),
    .o_detect_pwr (o_detect_pwr),
    .o_detect_idx (o_detect_idx),
`ifdef TUNER_PWR_DETECT_MIN_EN
    .o_detect_min_pwr (o_detect_min_pwr),
    .o_detect_min_idx (o_detect_min_idx),
`endif
    .o_busy       (o_busy)
  );

  typedef struct {
    int p0;
    int p1;
    int idx;
  } beat_t;

  typedef struct {
    int v0[4];
    int v1[4];
    int e_p0, e_i0, e_p1, e_i1;
  } vec_t;

  beat_t bq[$];
  int    exp_pwr[NCH], exp_idx[NCH], exp_min[NCH], exp_mini[NCH];
  vec_t  tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present one beat and hold it until the DUT takes it.
  task automatic send_beat(input int p0, input int p1, input int idx, input bit last);
    int n;
    beat_t b;
    i_sample_pwr = {AW'(p1), AW'(p0)};
    i_sample_idx = IW'(idx);
    i_sweep_last = last;
    i_sample_val = 1'b1;
    n = 0;
    while (!o_sample_rdy && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("sample_rdy_wait", o_sample_rdy, 1);
    tick();
    i_sample_val = 1'b0;
    i_sweep_last = 1'b0;
    b.p0 = p0; b.p1 = p1; b.idx = idx;
    bq.push_back(b);
  endtask

  // Sweep beats form consecutive groups of GRP; a short tail is a discarded partial group.
  task automatic model();
    int ng, s, avg;
    ng = bq.size() / GRP;
    for (int c = 0; c < NCH; c++) begin
      exp_pwr[c] = 0; exp_idx[c] = 0; exp_min[c] = 0; exp_mini[c] = 0;
      for (int g = 0; g < ng; g++) begin
        s = 0;
        for (int b = 0; b < GRP; b++) s += (c == 0) ? bq[g*GRP+b].p0 : bq[g*GRP+b].p1;
        avg = s / GRP;
        if (g == 0 || avg > exp_pwr[c]) begin exp_pwr[c] = avg; exp_idx[c] = bq[g*GRP].idx; end
        if (g == 0 || avg < exp_min[c]) begin exp_min[c] = avg; exp_mini[c] = bq[g*GRP].idx; end
      end
    end
  endtask

  task automatic check_payload(input string tag);
    model();
    for (int c = 0; c < NCH; c++) begin
      chk({tag, "_pwr"}, o_detect_pwr[c*AW +: AW], exp_pwr[c]);
      chk({tag, "_idx"}, o_detect_idx[c*IW +: IW], exp_idx[c]);
`ifdef TUNER_PWR_DETECT_MIN_EN
      chk({tag, "_min_pwr"}, o_detect_min_pwr[c*AW +: AW], exp_min[c]);
      chk({tag, "_min_idx"}, o_detect_min_idx[c*IW +: IW], exp_mini[c]);
`endif
    end
  endtask

  task automatic handshake(input string tag);
    i_detect_rdy = 1'b1;
    tick();
    i_detect_rdy = 1'b0;
    chk({tag, "_val_drop"}, o_detect_val, 0);
    bq.delete();
  endtask

  task automatic check_report(input string tag);
    int n;
    n = 0;
    while (!o_detect_val && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_val"}, o_detect_val, 1);
    check_payload(tag);
    handshake(tag);
  endtask

  task automatic const_steps(input int v0, input int v1, input int idx, input int nb, input bit last);
    for (int b = 0; b < nb; b++) send_beat(v0, v1, idx, last && (b == nb - 1));
  endtask

  initial begin
    i_rst_n = 1'b0; i_active = 1'b0; i_refresh = 1'b0; i_sample_val = 1'b0;
    i_sweep_last = 1'b0; i_detect_rdy = 1'b0; i_sample_pwr = '0; i_sample_idx = '0;

    tbl[0].v0 = '{10, 50, 30, 20};  tbl[0].v1 = '{40, 40, 5, 5};
    tbl[0].e_p0 = 50;  tbl[0].e_i0 = 1; tbl[0].e_p1 = 40;  tbl[0].e_i1 = 0;
    tbl[1].v0 = '{5, 5, 5, 5};      tbl[1].v1 = '{1, 2, 3, 4};
    tbl[1].e_p0 = 5;   tbl[1].e_i0 = 0; tbl[1].e_p1 = 4;   tbl[1].e_i1 = 3;
    tbl[2].v0 = '{255, 0, 255, 0};  tbl[2].v1 = '{0, 0, 0, 7};
    tbl[2].e_p0 = 255; tbl[2].e_i0 = 0; tbl[2].e_p1 = 7;   tbl[2].e_i1 = 3;
    tbl[3].v0 = '{100, 101, 99, 101}; tbl[3].v1 = '{200, 199, 201, 0};
    tbl[3].e_p0 = 101; tbl[3].e_i0 = 1; tbl[3].e_p1 = 201; tbl[3].e_i1 = 2;
    tbl[4].v0 = '{80, 12, 12, 90};  tbl[4].v1 = '{3, 9, 9, 1};
    tbl[4].e_p0 = 90;  tbl[4].e_i0 = 3; tbl[4].e_p1 = 9;   tbl[4].e_i1 = 1;

    repeat (2) tick();
    chk("rst_sample_rdy", o_sample_rdy, 0);
    chk("rst_detect_val", o_detect_val, 0);
    chk("rst_detect_pwr", o_detect_pwr, 0);
    chk("rst_detect_idx", o_detect_idx, 0);
    chk("rst_busy", o_busy, 0);
    i_rst_n = 1'b1;
    tick();
    chk("idle_busy", o_busy, 0);
    i_active = 1'b1;

    // Table vectors: four steps of four identical beats, idx = step number.
    for (int v = 0; v < 5; v++) begin
      for (int s = 0; s < 4; s++) const_steps(tbl[v].v0[s], tbl[v].v1[s], s, GRP, s == 3);
      chk("tbl_lat_t1", o_detect_val, 0);
      tick();
      chk("tbl_lat_t2", o_detect_val, 1);
      chk("tbl_p0", o_detect_pwr[0 +: AW], tbl[v].e_p0);
      chk("tbl_i0", o_detect_idx[0 +: IW], tbl[v].e_i0);
      chk("tbl_p1", o_detect_pwr[AW +: AW], tbl[v].e_p1);
      chk("tbl_i1", o_detect_idx[IW +: IW], tbl[v].e_i1);
`ifdef TUNER_PWR_DETECT_MIN_EN
      if (v == 4) begin
        chk("tbl_min_p0", o_detect_min_pwr[0 +: AW], 12);
        chk("tbl_min_i0", o_detect_min_idx[0 +: IW], 1);
      end
`endif
      handshake("tbl");
    end

    // Truncating average: (3+3+3+4)/4 = 3.
    send_beat(3, 3, 7, 0); send_beat(3, 3, 7, 0); send_beat(3, 3, 7, 0); send_beat(4, 4, 7, 1);
    tick();
    chk("trunc_val", o_detect_val, 1);
    chk("trunc_p0", o_detect_pwr[0 +: AW], 3);
    chk("trunc_i0", o_detect_idx[0 +: IW], 7);
    handshake("trunc");

    // Backpressure: result held while ready is low, input side stalled.
    const_steps(70, 20, 4, GRP, 0);
    const_steps(30, 90, 6, GRP, 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_val", o_detect_val, 1);
      chk("bp_sample_rdy", o_sample_rdy, 0);
      check_payload("bp");
      tick();
    end
    handshake("bp");
    const_steps(11, 22, 1, GRP, 1);
    check_report("after_bp");

    // Partial group carrying 255 is discarded.
    const_steps(20, 20, 0, GRP, 0);
    const_steps(30, 30, 1, GRP, 0);
    send_beat(255, 255, 2, 0);
    send_beat(255, 255, 2, 1);
    tick();
    chk("partial_p0", o_detect_pwr[0 +: AW], 30);
    chk("partial_i0", o_detect_idx[0 +: IW], 1);
    check_report("partial");

    // Sweep with only a partial group reports zeros.
    send_beat(99, 99, 5, 1);
    check_report("no_full");

    // Refresh after a 200 peak restarts the sweep.
    const_steps(200, 200, 5, GRP, 0);
    i_refresh = 1'b1;
    tick();
    i_refresh = 1'b0;
    bq.delete();
    const_steps(10, 10, 8, GRP, 0);
    const_steps(60, 60, 9, GRP, 0);
    const_steps(20, 20, 10, GRP, 1);
    tick();
    chk("refresh_p0", o_detect_pwr[0 +: AW], 60);
    chk("refresh_i0", o_detect_idx[0 +: IW], 9);
    check_report("refresh");

    // Abort by dropping active mid-sweep.
    const_steps(220, 220, 3, GRP + 1, 0);
    i_active = 1'b0;
    tick();
    chk("abort_busy", o_busy, 0);
    for (int i = 0; i < 5; i++) begin
      chk("abort_val", o_detect_val, 0);
      tick();
    end
    bq.delete();
    i_active = 1'b1;
    const_steps(50, 40, 2, GRP, 1);
    check_report("post_abort");

    // Reset mid-sweep.
    const_steps(230, 230, 3, GRP + 2, 0);
    i_rst_n = 1'b0;
    i_active = 1'b0;
    tick();
    i_rst_n = 1'b1;
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_pwr", o_detect_pwr, 0);
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_val", o_detect_val, 0);
      tick();
    end
    bq.delete();
    i_active = 1'b1;

    // Random sweeps against the model.
    for (int r = 0; r < 25; r++) begin
      int ns, nb;
      ns = $urandom_range(1, 5);
      for (int s = 0; s < ns; s++) begin
        nb = (s == ns - 1) ? $urandom_range(1, GRP) : GRP;
        for (int b = 0; b < nb; b++) begin
          send_beat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    (s == ns - 1) && (b == nb - 1));
          repeat ($urandom_range(0, 1)) tick();
        end
      end
      repeat ($urandom_range(0, 3)) tick();
      check_report("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
